// File: rtl/cgra_sram_banked_mem_pkg.sv
// cgra_mem_pkg: shared types, default sizes and address helpers for the banked scratchpad
package cgra_mem_pkg;
  localparam int NUM_PORTS = 4;
  localparam int NUM_BANKS = 4;
  localparam int WORDS_PER_BANK = 256;
  localparam int DATA_WIDTH = 32;
  localparam int WAKE_CYCLES = 4;
  localparam int BANK_SEL_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam int BANK_BITS = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 0;
  localparam int ADDR_WIDTH = $clog2(NUM_BANKS * WORDS_PER_BANK);
  localparam int ROW_W = $clog2(WORDS_PER_BANK);
  localparam int PORT_W = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {RET_ACTIVE, RET_DRAIN, RET_RETAINED, RET_WAKE} ret_state_e;
  typedef logic [BANK_SEL_W-1:0] bank_idx_t;
  typedef logic [PORT_W-1:0] port_idx_t;
  typedef logic [ROW_W-1:0] row_idx_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  function automatic bank_idx_t bank_of(addr_t a);
    return NUM_BANKS == 1 ? '0 : a[BANK_SEL_W-1:0];
  endfunction
  function automatic row_idx_t row_of(addr_t a);
    return row_idx_t'(a >> BANK_BITS);
  endfunction
endpackage

// File: rtl/cgra_sram_banked_mem_if.sv
// cgra_sram_banked_mem_if: request/response bus between CGRA column masters and the scratchpad
interface cgra_sram_banked_mem_if
  import cgra_mem_pkg::*;
#(
  parameter int NumPorts = NUM_PORTS,
  parameter int AddrWidth = ADDR_WIDTH,
  parameter int DataWidth = DATA_WIDTH
);
  localparam int BeWidth = DataWidth / 8;
  logic [NumPorts-1:0] req_i;
  logic [NumPorts-1:0] we_i;
  logic [NumPorts*AddrWidth-1:0] addr_i;
  logic [NumPorts*DataWidth-1:0] wdata_i;
  logic [NumPorts*BeWidth-1:0] be_i;
  logic [NumPorts-1:0] gnt_o;
  logic [NumPorts-1:0] rvalid_o;
  logic [NumPorts*DataWidth-1:0] rdata_o;
  modport master(output req_i, we_i, addr_i, wdata_i, be_i, input gnt_o, rvalid_o, rdata_o);
  modport slave(input req_i, we_i, addr_i, wdata_i, be_i, output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/cgra_rr_arbiter.sv
// cgra_rr_arbiter: round-robin arbiter whose pointer moves just past the last winner
module cgra_rr_arbiter #(
  parameter int NumPorts = 4,
  localparam int PortW = NumPorts > 1 ? $clog2(NumPorts) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPorts-1:0] req_i,
  input  logic                advance_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [PortW-1:0]    idx_o
);
  logic [PortW-1:0] ptr_q, ptr_d;
  logic found;
  // Pick the first requester at or after the pointer and compute the next pointer
  always_comb begin
    found = 1'b0;
    idx_o = ptr_q;
    for (int i = 0; i < NumPorts; i++) begin
      if (!found && req_i[(int'(ptr_q) + i) % NumPorts]) begin
        found = 1'b1;
        idx_o = PortW'((int'(ptr_q) + i) % NumPorts);
      end
    end
    gnt_o = found ? NumPorts'(1) << idx_o : '0;
    ptr_d = advance_i && found ? (idx_o == PortW'(NumPorts - 1) ? '0 : idx_o + 1'b1) : ptr_q;
  end
  // Pointer register
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/sram_wrapper.sv
// sram_wrapper: single-port byte-writable bank with registered read data and retention input
module sram_wrapper #(
  parameter int DataWidth = 32,
  parameter int WordsPerBank = 256,
  localparam int RowW = $clog2(WordsPerBank),
  localparam int BeWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [RowW-1:0]      addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  input  logic                 set_retentive_ni,
  output logic [DataWidth-1:0] rdata_o
);
  logic [DataWidth-1:0] mem_q [WordsPerBank];
  logic [DataWidth-1:0] rdata_q;
  // Array access; a bank in retention ignores the port
  always_ff @(posedge clk_i) begin
    if (en_i && set_retentive_ni) begin
      if (we_i) begin
        for (int i = 0; i < BeWidth; i++) if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/cgra_sram_banked_mem.sv
// cgra_sram_banked_mem: word-interleaved multi-port banked scratchpad with retention control
module cgra_sram_banked_mem
  import cgra_mem_pkg::*;
#(
  parameter int NumPorts = NUM_PORTS,
  parameter int NumBanks = NUM_BANKS,
  parameter int WordsPerBank = WORDS_PER_BANK,
  parameter int DataWidth = DATA_WIDTH,
  parameter int WakeCycles = WAKE_CYCLES
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  cgra_sram_banked_mem_if.slave        bus,
  input  logic                         ret_req_i,
  output logic                         ret_ack_o
);
  localparam int BeWidth = DataWidth / 8;
  localparam int BankSelW = NumBanks > 1 ? $clog2(NumBanks) : 1;
  localparam int BankBits = NumBanks > 1 ? $clog2(NumBanks) : 0;
  localparam int AddrWidth = $clog2(NumBanks * WordsPerBank);
  localparam int RowW = $clog2(WordsPerBank);
  localparam int PortW = NumPorts > 1 ? $clog2(NumPorts) : 1;
  localparam int CntW = $clog2(WakeCycles + 1);
  ret_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic active, retained;
  logic [BankSelW-1:0] bank_sel [NumPorts];
  logic [RowW-1:0] row_sel [NumPorts];
  logic [NumPorts-1:0] bank_gnt [NumBanks];
  logic [NumBanks-1:0] resp_v;
  logic [PortW-1:0] resp_port [NumBanks];
  logic [DataWidth-1:0] bank_rdata [NumBanks];
  logic [NumPorts-1:0] gnt, rvalid;
  logic [NumPorts-1:0][DataWidth-1:0] rsel, hold_q;
  // Retention state and wake counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RET_ACTIVE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // Next state; drain needs one cycle only since no grant is issued in it
  always_comb begin
    state_d = state_q;
    cnt_d = state_q == RET_WAKE ? cnt_q + 1'b1 : '0;
    case (state_q)
      RET_ACTIVE:   state_d = ret_req_i ? RET_DRAIN : RET_ACTIVE;
      RET_DRAIN:    state_d = RET_RETAINED;
      RET_RETAINED: state_d = ret_req_i ? RET_RETAINED : RET_WAKE;
      RET_WAKE:     state_d = cnt_q == CntW'(WakeCycles - 1) ? RET_ACTIVE : RET_WAKE;
      default:      state_d = RET_ACTIVE;
    endcase
  end
  assign active = state_q == RET_ACTIVE && !rst_i;
  assign retained = state_q == RET_RETAINED;
  assign ret_ack_o = retained;
  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic [AddrWidth-1:0] addr;
    assign addr = bus.addr_i[p*AddrWidth +: AddrWidth];
    assign bank_sel[p] = NumBanks == 1 ? '0 : addr[BankSelW-1:0];
    assign row_sel[p] = RowW'(addr >> BankBits);
  end
  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [NumPorts-1:0] breq;
    logic [PortW-1:0] widx, rport_q;
    logic bwe, rv_q;
    for (genvar p = 0; p < NumPorts; p++) begin : g_req
      assign breq[p] = active && bus.req_i[p] && bank_sel[p] == BankSelW'(b);
    end
    cgra_rr_arbiter #(.NumPorts(NumPorts)) u_arb (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(breq), .advance_i(active),
      .gnt_o(bank_gnt[b]), .idx_o(widx)
    );
    assign bwe = bus.we_i[widx];
    sram_wrapper #(.DataWidth(DataWidth), .WordsPerBank(WordsPerBank)) u_sram (
      .clk_i(clk_i), .en_i(|breq), .we_i(bwe), .addr_i(row_sel[widx]),
      .wdata_i(bus.wdata_i[widx*DataWidth +: DataWidth]),
      .be_i(bus.be_i[widx*BeWidth +: BeWidth]),
      .set_retentive_ni(!retained), .rdata_o(bank_rdata[b])
    );
    // Remember which port owns the read data the bank returns next cycle
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rv_q <= 1'b0;
        rport_q <= '0;
      end else begin
        rv_q <= |breq && !bwe;
        rport_q <= widx;
      end
    end
    assign resp_v[b] = rv_q;
    assign resp_port[b] = rport_q;
  end
  // Merge bank grants and route bank responses back to their ports
  always_comb begin
    gnt = '0;
    rvalid = '0;
    rsel = '0;
    for (int i = 0; i < NumBanks; i++) begin
      gnt = gnt | bank_gnt[i];
      for (int j = 0; j < NumPorts; j++) begin
        if (resp_v[i] && resp_port[i] == PortW'(j)) begin
          rvalid[j] = 1'b1;
          rsel[j] = rsel[j] | bank_rdata[i];
        end
      end
    end
  end
  // Keep the last delivered word on each port while rvalid is low
  always_ff @(posedge clk_i) begin
    if (rst_i) hold_q <= '0;
    else for (int i = 0; i < NumPorts; i++) if (rvalid[i]) hold_q[i] <= rsel[i];
  end
  for (genvar p = 0; p < NumPorts; p++) begin : g_out
    assign bus.rdata_o[p*DataWidth +: DataWidth] = rvalid[p] ? rsel[p] : hold_q[p];
  end
  assign bus.gnt_o = gnt;
  assign bus.rvalid_o = rvalid;
endmodule
